// File: rtl/syscall_pkg.sv
// ---------------------------------------------------------------------------
// syscall_pkg : shared constants and state types for the syscall responder
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package syscall_pkg;

    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SYS_PRINT_HEX  = 32'd34;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_X     = 8'h78;
    localparam logic [7:0] ASCII_LC_A  = 8'h61;
    localparam logic [7:0] ASCII_UC_A  = 8'h41;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_EMIT    = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_CHAR = 2'd0,
        MODE_HEX  = 2'd1,
        MODE_INT  = 2'd2
    } mode_e;

endpackage

`default_nettype wire

// File: rtl/bin_to_bcd.sv
// ---------------------------------------------------------------------------
// bin_to_bcd : sequential double-dabble, 32-bit binary to 10-digit BCD
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module bin_to_bcd #(
    parameter int CONV_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] bin_i,
    output logic        done_o,
    output logic [39:0] bcd_o
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      bin_q;
    logic [39:0]      bcd_q;
    logic [39:0]      adj;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            bin_q <= '0;
            bcd_q <= '0;
        end else if (start_i) begin
            cnt_q <= CNT_W'(CONV_CYCLES);
            bin_q <= bin_i;
            bcd_q <= '0;
        end else if (cnt_q != '0) begin
            {bcd_q, bin_q} <= {adj, bin_q} << 1;
            cnt_q          <= cnt_q - CNT_W'(1);
        end
    end

    // High during the final iteration, so the result is settled the cycle after
    assign done_o = (cnt_q == CNT_W'(1));
    assign bcd_o  = bcd_q;

endmodule

`default_nettype wire

// File: rtl/syscall_responder.sv
// ---------------------------------------------------------------------------
// syscall_responder : services print-int/char/hex and exit syscalls, streams ASCII
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module syscall_responder
    import syscall_pkg::*;
#(
    parameter bit HEX_UPPER   = 1'b0,
    parameter int CONV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [31:0] req_funct,
    input  logic [31:0] req_param,
    output logic        req_ready,
    output logic        busy,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        halted,
    output logic        err_unknown
);

    state_e      state_q;
    mode_e       mode_q;
    logic [31:0] data_q;
    logic        sign_q;
    logic [3:0]  idx_q;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic        halted_q;
    logic        err_q;

    logic        accept;
    logic        conv_start;
    logic [31:0] magnitude;
    logic        bcd_done;
    logic [39:0] bcd;
    logic [3:0]  first_nz;
    logic [3:0]  last_idx;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASCII_ZERO + {4'd0, n};
        end
        return (HEX_UPPER ? ASCII_UC_A : ASCII_LC_A) + {4'd0, n} - 8'd10;
    endfunction

    function automatic logic [7:0] byte_at(input mode_e m, input logic [3:0] idx,
                                           input logic neg, input logic [31:0] data,
                                           input logic [39:0] digits);
        int sh;
        sh = 4 * (9 - int'(idx));
        case (m)
            MODE_HEX: begin
                if (idx == 4'd0)      return ASCII_ZERO;
                else if (idx == 4'd1) return ASCII_X;
                else                  return hex_ascii(4'(data >> sh));
            end
            MODE_INT: begin
                if (neg) return ASCII_MINUS;
                else     return ASCII_ZERO + {4'd0, 4'(digits >> sh)};
            end
            default:  return data[7:0];
        endcase
    endfunction

    assign req_ready  = (state_q == ST_IDLE) && !halted_q;
    assign busy       = (state_q != ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign conv_start = accept && (req_funct == SYS_PRINT_INT);
    // Two's-complement negate; 0x80000000 maps onto itself, read as unsigned 2^31
    assign magnitude  = req_param[31] ? (~req_param + 32'd1) : req_param;
    assign last_idx   = (mode_q == MODE_CHAR) ? 4'd0 : 4'd9;

    always_comb begin
        first_nz = 4'd9;
        for (int i = 9; i >= 0; i--) begin
            if (bcd[39-4*i -: 4] != 4'd0) begin
                first_nz = 4'(i);
            end
        end
    end

    bin_to_bcd #(
        .CONV_CYCLES (CONV_CYCLES)
    ) u_bin_to_bcd (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .start_i (conv_start),
        .bin_i   (magnitude),
        .done_o  (bcd_done),
        .bcd_o   (bcd)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_CHAR;
            data_q      <= '0;
            sign_q      <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_q <= req_param;
                        idx_q  <= '0;
                        sign_q <= 1'b0;
                        if (req_funct == SYS_PRINT_CHAR) begin
                            mode_q  <= MODE_CHAR;
                            state_q <= ST_EMIT;
                        end else if (req_funct == SYS_PRINT_HEX) begin
                            mode_q  <= MODE_HEX;
                            state_q <= ST_EMIT;
                        end else if (req_funct == SYS_PRINT_INT) begin
                            mode_q  <= MODE_INT;
                            sign_q  <= req_param[31];
                            state_q <= ST_CONVERT;
                        end else if (req_funct == SYS_EXIT) begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_CONVERT: begin
                    if (bcd_done) begin
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (!out_valid_q) begin
                        // First byte: integers skip straight past leading zero digits
                        out_valid_q <= 1'b1;
                        if (mode_q == MODE_INT) begin
                            idx_q      <= first_nz;
                            out_data_q <= byte_at(mode_q, first_nz, sign_q, data_q, bcd);
                        end else begin
                            out_data_q <= byte_at(mode_q, idx_q, 1'b0, data_q, bcd);
                        end
                    end else if (out_ready) begin
                        if ((mode_q == MODE_INT) && sign_q) begin
                            sign_q     <= 1'b0;
                            out_data_q <= byte_at(mode_q, idx_q, 1'b0, data_q, bcd);
                        end else if (idx_q == last_idx) begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            idx_q      <= idx_q + 4'd1;
                            out_data_q <= byte_at(mode_q, idx_q + 4'd1, 1'b0, data_q, bcd);
                        end
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign halted      = halted_q;
    assign err_unknown = err_q;

endmodule

`default_nettype wire

// File: tb/tb_syscall_responder.sv
// ---------------------------------------------------------------------------
// tb_syscall_responder : directed scoreboard bench for syscall_responder
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_syscall_responder;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_funct = '0;
    logic [31:0] req_param = '0;
    logic        out_ready = 1'b0;
    logic        req_ready;
    logic        busy;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        halted;
    logic        err_unknown;

    int          vectors = 0;
    int          errors  = 0;
    logic [7:0]  exp_q[$];
    logic        hold    = 1'b0;
    logic [7:0]  held    = 8'h00;

    syscall_responder #(
        .HEX_UPPER   (1'b0),
        .CONV_CYCLES (32)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_funct   (req_funct),
        .req_param   (req_param),
        .req_ready   (req_ready),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .halted      (halted),
        .err_unknown (err_unknown)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic send(input logic [31:0] f, input logic [31:0] p);
        int t = 0;
        while (!req_ready && t < 50) begin
            tick();
            t++;
        end
        check("req_ready_before_send", req_ready, 1'b1);
        req_valid = 1'b1;
        req_funct = f;
        req_param = p;
        tick();
        req_valid = 1'b0;
        req_funct = $urandom;
        req_param = $urandom;
    endtask

    task automatic drain(input int bound, input bit toggle);
        int t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            if (toggle) out_ready = ~out_ready;
            tick();
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Scoreboard: every transferred byte must match the oldest expected byte
    always @(negedge clock) begin
        logic [7:0] e;
        if (!reset_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else                   e = 8'hxx;
                check("byte", out_data, e);
            end
            hold = out_valid && !out_ready;
            held = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b1;
        tick(2);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_halted", halted, 1'b0);
        check("rst_err", err_unknown, 1'b0);
        reset_n = 1'b1;
        tick();

        // Print char
        push_str("A");
        send(32'd11, 32'h41);
        check("char_busy", busy, 1'b1);
        check("char_valid_late", out_valid, 1'b0);
        tick();
        check("char_valid", out_valid, 1'b1);
        check("char_data", out_data, 8'h41);
        tick();
        check("char_valid_drop", out_valid, 1'b0);
        check("char_busy_drop", busy, 1'b0);
        check("char_ready", req_ready, 1'b1);
        check("char_consumed", exp_q.size(), 0);

        // Print negative int with exact conversion latency
        push_str($sformatf("%0d", $signed(-32'sd305)));
        send(32'd1, -32'sd305);
        for (int i = 0; i < 33; i++) begin
            check("conv_busy_novalid", {busy, out_valid}, 2'b10);
            tick();
        end
        check("int_first_valid", out_valid, 1'b1);
        check("int_first_data", out_data, 8'h2D);
        drain(20, 1'b0);
        check("int_busy_done", busy, 1'b0);

        // Zero and most negative value
        push_str("0");
        send(32'd1, 32'd0);
        drain(60, 1'b0);
        push_str($sformatf("%0d", $signed(32'h80000000)));
        send(32'd1, 32'h80000000);
        drain(80, 1'b0);

        // Hex with a toggling sink
        push_str($sformatf("0x%08h", 32'h00ABCDEF));
        send(32'd34, 32'h00ABCDEF);
        drain(60, 1'b1);
        out_ready = 1'b1;
        tick(2);
        check("hex_busy_done", busy, 1'b0);

        // Unknown funct, then exit
        send(32'd99, 32'h1234);
        check("unk_err", err_unknown, 1'b1);
        check("unk_busy", busy, 1'b0);
        check("unk_ready", req_ready, 1'b1);
        tick();
        check("unk_err_pulse", err_unknown, 1'b0);
        check("unk_no_byte", out_valid, 1'b0);
        send(32'd10, 32'd0);
        check("exit_halted", halted, 1'b1);
        check("exit_ready", req_ready, 1'b0);
        req_valid = 1'b1;
        req_funct = 32'd11;
        req_param = 32'h42;
        tick(5);
        req_valid = 1'b0;
        check("halt_sticky", halted, 1'b1);
        check("halt_ready", req_ready, 1'b0);
        check("halt_no_byte", out_valid, 1'b0);

        reset_n = 1'b0;
        #1;
        check("rst_clears_halt", halted, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();

        // Reset in the middle of an integer string
        push_str("12");
        send(32'd1, 32'd12345);
        begin
            int t = 0;
            while (exp_q.size() != 0 && t < 80) begin
                tick();
                t++;
            end
        end
        check("mid_two_sent", exp_q.size(), 0);
        check("mid_third_pending", out_valid, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        push_str("Z");
        send(32'd11, 32'h5A);
        drain(10, 1'b0);
        tick();
        check("final_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/syscall_responder.md
Name: syscall_responder

Overview:
- Service end of the pipeline's syscall request path. The decode stage raises a syscall with a function code and first parameter; this block accepts the request, performs the service, and streams the resulting ASCII bytes to a console byte sink.
- It asserts busy so the hazard unit holds the pipeline until the service completes.
- Services: print signed integer (1), exit (10), print char (11), print hex (34).

Parameters:
- HEX_UPPER, 0, 1 selects uppercase hex digits 'A'-'F'; 0 selects lowercase 'a'-'f'.
- CONV_CYCLES, 32, number of double-dabble iterations. Must equal the operand width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  syscall present in decode (syscallD).
- req_funct  in  32  function code ($v0).
- req_param  in  32  first parameter ($a0).
- req_ready  out  1  request accepted this cycle if req_valid=1.
- busy  out  1  service in progress; hazard unit stalls F/D while busy=1.
- out_valid  out  1  console byte valid.
- out_data  out  8  ASCII byte.
- out_ready  in  1  sink accepts byte.
- halted  out  1  sticky; exit syscall was serviced.
- err_unknown  out  1  one-cycle pulse when an unsupported funct is accepted.

Behaviour:
- Reset values: state=IDLE; req_ready=1, busy=0, out_valid=0, out_data=8'h00, halted=0, err_unknown=0.
- req_ready = (state==IDLE) && !halted. busy = (state!=IDLE). Accept = req_valid && req_ready.
- States:
  - IDLE: waits for accept.
  - CONVERT: binary-to-BCD conversion.
  - EMIT: byte streaming.
  - HALT: terminal.
- Accept, funct 11: move to EMIT with a single byte, req_param[7:0].
- Accept, funct 34: move to EMIT with 10 bytes: '0','x', then 8 hex nibbles MS-first. Leading zeros are kept.
- Accept, funct 1:
  - Latch sign = req_param[31] and magnitude = |req_param| as 32-bit unsigned. 32'h80000000 gives magnitude 2147483648 with no overflow.
  - Go to CONVERT for exactly CONV_CYCLES cycles, producing a 10-digit BCD result, then go to EMIT.
  - Emit '-' first if sign=1, then digits MS-first with leading zeros suppressed. Value 0 emits the single byte '0'.
- Accept, funct 10: next cycle halted=1 and state=HALT. No bytes are emitted. HALT is left only by reset.
- Accept, other funct: err_unknown pulses high on the cycle after accept. State remains IDLE; req_ready stays 1, so a new request can be accepted that cycle.
- EMIT handshake:
  - out_valid rises the cycle after entry to EMIT.
  - out_data is stable while out_valid && !out_ready.
  - A byte transfers on out_valid && out_ready; the next byte, if any, is presented the following cycle, giving one byte per cycle at full throughput.
  - After the last transfer: out_valid=0 and state=IDLE on the next edge.
- Output is byte-exact: no newline or terminator is appended.
- req_funct/req_param are sampled only at accept. Later changes while busy are ignored.
- Reset asserted mid-CONVERT or mid-EMIT: immediate return to reset values. The partial string is abandoned, and halted clears.
- out_ready held low indefinitely: the block stays in EMIT and busy stays 1. There is no timeout.

Decomposition:
- Package syscall_pkg holds:
  - funct constants SYS_PRINT_INT=1, SYS_EXIT=10, SYS_PRINT_CHAR=11, SYS_PRINT_HEX=34;
  - ASCII constants for '0', '-', 'x', 'a', 'A';
  - the state enumeration.
- Sub-module bin_to_bcd: sequential double-dabble with start/done, 32-bit in, 40-bit BCD out, fixed CONV_CYCLES latency.
- The top holds the FSM, byte sequencer (digit index, leading-zero flag) and nibble-to-ASCII mapping.

Test Plan:
- funct=11, param=0x41, out_ready=1 -> single byte 0x41, out_valid high 1 cycle; busy falls and req_ready=1 the cycle after.
- funct=1, param=-305 -> bytes '-','3','0','5'; first out_valid 33 cycles after accept; busy high throughout.
- funct=1, param=0, then param=0x80000000 -> "0"; then "-2147483648" (11 bytes).
- funct=34, param=0x00ABCDEF, HEX_UPPER=0, out_ready toggling 1/0 -> "0x00abcdef"; out_data stable during every out_ready=0 cycle; no byte lost or duplicated.
- funct=99 -> err_unknown one-cycle pulse, no bytes. Then funct=10 -> halted=1 sticky, req_ready=0; a further funct=11 is not accepted.
- reset_n low mid-EMIT of print-int 12345 after 2 bytes -> out_valid=0 and busy=0 immediately. After release, a fresh funct=11 prints correctly.
